// File: rtl/id_stage.sv
// RV32I instruction-decode stage: 1-cycle decode into an output register backed by one skid entry.
// Optional illegal-instruction detection is compiled in when ID_ILLEGAL_DETECT_EN is defined.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    bundle_t dec_bundle;
    logic    dec_illegal;

    always_comb begin
        dec_bundle         = '0;
        dec_bundle.opcode  = in_instr[6:0];
        dec_bundle.rd      = in_instr[11:7];
        dec_bundle.funct3  = in_instr[14:12];
        dec_bundle.rs1     = in_instr[19:15];
        dec_bundle.rs2     = in_instr[24:20];
        dec_bundle.funct7  = in_instr[31:25];
        dec_bundle.pc      = in_pc;
        dec_bundle.illegal = dec_illegal;
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                dec_bundle.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            OP_STORE:
                dec_bundle.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OP_BRANCH:
                dec_bundle.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                dec_bundle.imm = {in_instr[31:12], 12'b0};
            OP_JAL:
                dec_bundle.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0};
            default:
                dec_bundle.imm = 32'd0;
        endcase
    end

`ifdef ID_ILLEGAL_DETECT_EN
    localparam int NUM_LEGAL_OPS = 11;
    localparam logic [NUM_LEGAL_OPS*7-1:0] LEGAL_OP_TABLE = {
        OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI,
        OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_FENCE
    };

    logic [NUM_LEGAL_OPS-1:0] op_hit;
    logic [6:0]               ill_opcode;
    logic [2:0]               ill_funct3;
    logic [6:0]               ill_funct7;

    assign ill_opcode = in_instr[6:0];
    assign ill_funct3 = in_instr[14:12];
    assign ill_funct7 = in_instr[31:25];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEGAL_OPS; gi++) begin : g_op_match
            assign op_hit[gi] = (ill_opcode == LEGAL_OP_TABLE[gi*7 +: 7]);
        end
    endgenerate

    always_comb begin
        dec_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end
        if (op_hit == '0) begin
            dec_illegal = 1'b1;
        end
        if (ill_opcode == OP_REG) begin
            if (ill_funct7 != F7_BASE && ill_funct7 != F7_ALT) begin
                dec_illegal = 1'b1;
            end
            // Only SUB and SRA use the alternate funct7 encoding
            if (ill_funct7 == F7_ALT && ill_funct3 != 3'b000 && ill_funct3 != 3'b101) begin
                dec_illegal = 1'b1;
            end
        end
        if (ill_opcode == OP_IMM) begin
            if (ill_funct3 == 3'b001 && ill_funct7 != F7_BASE) begin
                dec_illegal = 1'b1;
            end
            if (ill_funct3 == 3'b101 && ill_funct7 != F7_BASE && ill_funct7 != F7_ALT) begin
                dec_illegal = 1'b1;
            end
        end
    end
`else
    assign dec_illegal = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output register + skid entry
    // ------------------------------------------------------------------
    bundle_t out_reg,  out_next;
    bundle_t skid_reg, skid_next;
    logic    out_valid_reg,  out_valid_next;
    logic    skid_valid_reg, skid_valid_next;
    logic    in_ready_reg,   in_ready_next;
    logic    in_xfer;
    logic    out_xfer;

    assign in_xfer  = in_valid && in_ready_reg;
    assign out_xfer = out_valid_reg && out_ready;

    always_comb begin
        out_next        = out_reg;
        skid_next       = skid_reg;
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;

        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid_reg) begin
            // in_ready is low here, so only the drain side can move
            if (out_xfer) begin
                out_next        = skid_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end
        end else if (!out_valid_reg || out_xfer) begin
            out_valid_next = in_xfer;
            if (in_xfer) begin
                out_next = dec_bundle;
            end
        end else if (in_xfer) begin
            skid_next       = dec_bundle;
            skid_valid_next = 1'b1;
        end

        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            out_reg        <= out_next;
            skid_reg       <= skid_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= in_ready_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_opcode  = out_reg.opcode;
    assign out_funct3  = out_reg.funct3;
    assign out_funct7  = out_reg.funct7;
    assign out_rs1     = out_reg.rs1;
    assign out_rs2     = out_reg.rs2;
    assign out_rd      = out_reg.rd;
    assign out_imm     = out_reg.imm;
    assign out_pc      = out_reg.pc;
    assign out_illegal = out_reg.illegal;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port flush, input, 1 bit: discards all held instructions.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream instruction valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept an instruction.
REQ-006 The block SHALL have port in_instr, input, 32 bits: raw RV32I instruction word.
REQ-007 The block SHALL have port in_pc, input, 32 bits: PC of in_instr.
REQ-008 The block SHALL have port out_valid, output, 1 bit: decoded bundle valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream (ALU/execute) accepts the bundle.
REQ-010 The block SHALL have ports out_opcode (7 bits), out_funct3 (3 bits) and out_funct7 (7 bits), all outputs: ALU control fields.
REQ-011 The block SHALL have ports out_rs1, out_rs2 and out_rd, outputs, 5 bits each: register indices.
REQ-012 The block SHALL have ports out_imm and out_pc, outputs, 32 bits each: sign-extended immediate and pass-through PC.
REQ-013 The block SHALL have port out_illegal, output, 1 bit: the instruction in the bundle is illegal.

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-015 Storage SHALL be a main output register plus one skid entry (capacity 2); in_ready SHALL be a registered signal equal to "skid entry empty".
REQ-016 Latency SHALL be 1 cycle: a transfer accepted into an empty block SHALL appear on the outputs with out_valid=1 on the next cycle.
REQ-017 When the output register holds a bundle that is not taken (out_ready=0) and an input transfer occurs, the new bundle SHALL go to the skid entry; in_ready SHALL be 0 from the next cycle.
REQ-018 On an output transfer with the skid entry full, the skid bundle SHALL move to the output register and in_ready SHALL return to 1 on the next cycle.
REQ-019 A simultaneous input and output transfer with the skid entry empty SHALL load the new bundle directly into the output register, with no bubble.
REQ-020 Bundles SHALL leave the block in acceptance order, with none dropped or duplicated.
REQ-021 The outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 The decode fields SHALL be taken as: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25], for every opcode.
REQ-023 out_imm SHALL be formed according to opcode:
- I-type (0010011, 0000011, 1100111, 1110011): sext([31:20]).
- S-type (0100011): sext({[31:25],[11:7]}).
- B-type (1100011): sext({[31],[7],[30:25],[11:8],0}).
- U-type (0110111, 0010111): {[31:12], 12'b0}.
- J-type (1101111): sext({[31],[19:12],[20],[30:21],0}).
- All other opcodes, including 0110011: 0.
REQ-024 flush SHALL have priority over all other events: on the next cycle out_valid=0, the skid entry SHALL be empty and in_ready=1, and any input presented in the flush cycle SHALL be discarded.

Reset
REQ-025 While rst_n=0 the block SHALL hold out_valid=0, in_ready=1, skid entry empty, and all data outputs at 0.
REQ-026 Assertion of rst_n mid-transfer SHALL discard all held bundles immediately, without waiting for a clock edge.
REQ-027 The first input transfer SHALL be possible on the first rising edge of clk after rst_n deasserts.

Configuration
REQ-028 With macro ID_ILLEGAL_DETECT_EN defined, out_illegal SHALL be 1 for any of:
- [1:0]!=11;
- an opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 1110011, 0001111};
- 0110011 with funct7 not in {0000000, 0100000};
- 0110011 with funct7=0100000 and funct3 not in {000, 101};
- 0010011 with funct3=001 and funct7!=0000000;
- 0010011 with funct3=101 and funct7 not in {0000000, 0100000}.
REQ-029 Without ID_ILLEGAL_DETECT_EN, out_illegal SHALL be tied to 0 and the illegal-detection logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-030 Bench SHALL cover: in_instr=0xFFF10093, in_pc=0x100, out_ready=1 -> next cycle out_valid=1, opcode=0010011, rd=1, rs1=2, funct3=000, imm=0xFFFFFFFF, pc=0x100, illegal=0.
REQ-031 Bench SHALL cover: in_instr=0x402081B3 -> opcode=0110011, funct7=0100000, rs2=2, rs1=1, funct3=000, rd=3, imm=0.
REQ-032 Bench SHALL cover: in_instr=0x00000000 with ID_ILLEGAL_DETECT_EN defined -> illegal=1; same stimulus without the macro -> illegal=0.
REQ-033 Bench SHALL cover: out_ready=0 while beats A and B are sent back-to-back -> in_ready=0 after B; raising out_ready -> A then B on consecutive cycles, in_ready=1 one cycle after A leaves.
REQ-034 Bench SHALL cover: flush asserted with both entries full and in_valid=1 -> next cycle out_valid=0 and in_ready=1, and none of the three instructions ever appears on the outputs.
REQ-035 Bench SHALL cover: rst_n pulsed low between clock edges while out_valid=1 -> out_valid=0 immediately, before the next rising edge.
